// File: rtl/hero_write_rx_pkg.sv
// Shared types for the hero write receiver: cycle encoding, rx FSM states and the buffered beat.
package hero_write_rx_pkg;

   localparam int HERO_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      VALID = 2'd1,
      DONE  = 2'd2
   } CYCLE_TYPE_E;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BURST,
      S_DISCARD
   } HERO_RX_STATE_E;

   typedef struct packed {
      logic                  last;
      logic [HERO_WIDTH-1:0] data;
   } hero_rx_beat_t;

endpackage

// File: rtl/hero_write_rx_if.sv
// Hero ingress bus plus consumer stream and status; slave = receiver side, master = sender/consumer side.
// With HERO_WRITE_RX_PARITY_EN defined, hero_parity and err_parity are added.
interface hero_write_rx_if #(
   parameter int HERO_WIDTH = hero_write_rx_pkg::HERO_WIDTH,
   parameter int MAX_BEATS  = 16
);
   import hero_write_rx_pkg::*;

   localparam int LEN_W = $clog2(MAX_BEATS + 1);

   CYCLE_TYPE_E           hero_cycle;
   logic [HERO_WIDTH-1:0] hero_data;
   logic                  hero_stall;
   logic                  out_valid;
   logic                  out_ready;
   logic [HERO_WIDTH-1:0] out_data;
   logic                  out_last;
   logic                  burst_done;
   logic [LEN_W-1:0]      burst_len;
   logic                  err_overrun;
   logic                  err_protocol;
`ifdef HERO_WRITE_RX_PARITY_EN
   logic                  hero_parity;
   logic                  err_parity;
`endif

   modport slave (
`ifdef HERO_WRITE_RX_PARITY_EN
      input  hero_parity,
      output err_parity,
`endif
      input  hero_cycle, hero_data, out_ready,
      output hero_stall, out_valid, out_data, out_last,
      output burst_done, burst_len, err_overrun, err_protocol
   );

   modport master (
`ifdef HERO_WRITE_RX_PARITY_EN
      output hero_parity,
      input  err_parity,
`endif
      output hero_cycle, hero_data, out_ready,
      input  hero_stall, out_valid, out_data, out_last,
      input  burst_done, burst_len, err_overrun, err_protocol
   );

endinterface

// File: rtl/hero_rx_fifo.sv
// Synchronous beat FIFO: registered write, combinational head read, wrap-bit pointers.
module hero_rx_fifo
   import hero_write_rx_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  hero_rx_beat_t                push_beat,
   input  logic                         pop,
   output hero_rx_beat_t                head,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
   localparam logic [AW:0] AF_LEVEL = (AW+1)'(DEPTH - 1);

   hero_rx_beat_t mem [DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic [AW:0]   occ_next;
   logic          push_ok, pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok  = pop & ~empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign push_ok = push & (~full | pop_ok);
   assign count   = wr_ptr - rd_ptr;
   assign occ_next = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_beat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         almost_full <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
         almost_full <= (occ_next >= AF_LEVEL);
      end
   end

endmodule

// File: rtl/hero_write_rx.sv
// Hero write receiver: burst FSM, beat counter, error pulses and beat FIFO feeding a ready/valid stream.
// Optional even-parity check on hero_data when HERO_WRITE_RX_PARITY_EN is defined.
module hero_write_rx #(
   parameter int HERO_WIDTH = hero_write_rx_pkg::HERO_WIDTH,
   parameter int FIFO_DEPTH = 8,
   parameter int MAX_BEATS  = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   hero_write_rx_if.slave bus
);
   import hero_write_rx_pkg::*;

   localparam int LEN_W = $clog2(MAX_BEATS + 1);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam logic [LEN_W-1:0] LAST_CNT = LEN_W'(MAX_BEATS - 1);
   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BEATS);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FIFO_DEPTH);

   HERO_RX_STATE_E   state, state_next;
   logic [LEN_W-1:0] cnt, cnt_next;
   logic [LEN_W-1:0] len_q, len_next;
   logic             push_req, push_last, done_hit, proto_hit;
   logic             done_q, overrun_q, proto_q;

   hero_rx_beat_t    head;
   logic             fifo_full, fifo_empty, fifo_almost_full, pop;
   logic [CNT_W-1:0] fifo_count;
   logic [HERO_WIDTH-1:0] head_data;

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      len_next   = len_q;
      push_req   = 1'b0;
      push_last  = 1'b0;
      done_hit   = 1'b0;
      proto_hit  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (bus.hero_cycle == VALID) begin
               push_req   = 1'b1;
               cnt_next   = LEN_ONE;
               state_next = S_BURST;
            end else if (bus.hero_cycle == DONE) begin
               push_req  = 1'b1;
               push_last = 1'b1;
               done_hit  = 1'b1;
               len_next  = LEN_ONE;
            end
         end
         S_BURST: begin
            if (bus.hero_cycle == VALID) begin
               push_req = 1'b1;
               if (cnt == LAST_CNT) begin
                  push_last  = 1'b1;
                  done_hit   = 1'b1;
                  proto_hit  = 1'b1;
                  len_next   = MAX_LEN;
                  state_next = S_DISCARD;
               end else begin
                  cnt_next = cnt + LEN_ONE;
               end
            end else if (bus.hero_cycle == DONE) begin
               push_req   = 1'b1;
               push_last  = 1'b1;
               done_hit   = 1'b1;
               len_next   = cnt + LEN_ONE;
               state_next = S_IDLE;
            end
         end
         S_DISCARD: begin
            if (bus.hero_cycle == DONE) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         len_q     <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         proto_q   <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         len_q     <= len_next;
         done_q    <= done_hit;
         // dropped beats still advance the FSM and counter, so burst_done fires regardless
         overrun_q <= push_req & fifo_full & ~pop;
         proto_q   <= proto_hit;
      end
   end

   hero_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push_req),
      .push_beat   ('{last: push_last, data: bus.hero_data}),
      .pop         (pop),
      .head        (head),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .almost_full (fifo_almost_full),
      .count       (fifo_count)
   );

   count_bounded: assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= CNT_MAX);

   assign pop             = ~fifo_empty & bus.out_ready;
   assign head_data       = fifo_empty ? '0 : head.data;
   assign bus.out_valid   = ~fifo_empty;
   assign bus.out_data    = head_data;
   assign bus.out_last    = ~fifo_empty & head.last;
   assign bus.hero_stall  = fifo_almost_full;
   assign bus.burst_done  = done_q;
   assign bus.burst_len   = len_q;
   assign bus.err_overrun = overrun_q;
   assign bus.err_protocol = proto_q;

`ifdef HERO_WRITE_RX_PARITY_EN
   logic parity_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_q <= 1'b0;
      else        parity_q <= (bus.hero_cycle != IDLE) && (bus.hero_parity != ^bus.hero_data);
   end

   assign bus.err_parity = parity_q;
`endif

endmodule
